// File: rtl/pulse_gen.sv
// Programmable delayed-pulse generator: arm, wait `delay` ticks, drive a pulse of `width`+1 ticks.
// Optional PULSE_GEN_BURST_EN limits periodic mode to burst+1 pulses.
module pulse_gen #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             sysrst,
  input  logic [WIDTH-1:0] delay,
  input  logic [WIDTH-1:0] width,
  input  logic             periodic,
  input  logic             start,
  input  logic             stop,
  input  logic             count,
  input  logic             ack,
`ifdef PULSE_GEN_BURST_EN
  input  logic [7:0]       burst,
  output logic [7:0]       pulses_left,
`endif
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_PULSE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic             r_done, w_done_set;
  logic             w_pulse_end, w_last;

  // Natural end of a pulse; start/stop override it.
  assign w_pulse_end = !stop && !start && count && (r_state == S_PULSE) && (r_cnt == '0);

`ifdef PULSE_GEN_BURST_EN
  logic [7:0] r_pl;

  always_ff @(posedge clk or posedge sysrst) begin
    if (sysrst)                       r_pl <= 8'd0;
    else if (stop)                    r_pl <= 8'd0;
    else if (start)                   r_pl <= burst;
    else if (w_pulse_end && r_pl != 8'd0) r_pl <= r_pl - 8'd1;
  end

  assign w_last      = (r_pl == 8'd0);
  assign pulses_left = r_pl;
`else
  assign w_last = 1'b0;
`endif

  always_ff @(posedge clk or posedge sysrst) begin
    if (sysrst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_set | (r_done & ~ack);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_set  = 1'b0;
    if (stop) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else if (start) begin
      w_state_nxt = S_DELAY;
      w_cnt_nxt   = delay;
    end else if (count) begin
      unique case (r_state)
        S_DELAY: begin
          if (r_cnt != '0) w_cnt_nxt = r_cnt - WIDTH'(1);
          else begin
            w_state_nxt = S_PULSE;
            w_cnt_nxt   = width;
          end
        end
        S_PULSE: begin
          if (r_cnt != '0) w_cnt_nxt = r_cnt - WIDTH'(1);
          else if (periodic && !w_last) begin
            w_state_nxt = S_DELAY;
            w_cnt_nxt   = delay;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_set  = 1'b1;
          end
        end
        S_IDLE:  w_state_nxt = S_IDLE;
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs decode flops only; no input-to-output combinational path.
  always_comb begin
    out       = (r_state == S_PULSE);
    busy      = (r_state != S_IDLE);
    done      = r_done;
    remaining = r_cnt;
  end

endmodule

// File: doc/pulse_gen.md
Name: pulse_gen

Overview:
- Programmable delayed-pulse generator: the output-side companion to the event-measuring counter.
- After an arm (start), waits a loaded delay, then drives a pulse of loaded width.
- Supports one-shot and periodic modes.
- Used on the stimulus side of the bench to produce timed strobes, e.g. injected reset/clock edges, toward the target, while counters measure responses.

Parameters:
- WIDTH, 16, bit width of delay/width values and the internal down-counter.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- sysrst  input  1  asynchronous, active-high reset.
- delay  input  WIDTH  delay value; sampled on start and on each periodic reload.
- width  input  WIDTH  pulse width value; sampled on the DELAY->PULSE transition.
- periodic  input  1  1 = restart delay after each pulse; sampled at end of pulse.
- start  input  1  arm/restart strobe.
- stop  input  1  abort strobe.
- count  input  1  tick enable; counter advances only on cycles with count=1.
- ack  input  1  clears done.
- out  output  1  generated pulse (registered).
- busy  output  1  1 while in DELAY or PULSE.
- done  output  1  sticky: set when a one-shot pulse completes.
- remaining  output  WIDTH  current down-counter value.

Behaviour:
- States: IDLE, DELAY, PULSE. Internal down-counter cnt[WIDTH].
- Reset (asynchronous, any time, including mid-pulse): state=IDLE, cnt=0, out=0, busy=0, done=0. Remaining ticks are discarded.
- All outputs are registered. busy=(state!=IDLE). out=(state==PULSE). remaining=cnt.
- start (stop=0), any state: state=DELAY, cnt=delay, out=0.
  - Restart is allowed while running.
  - done is unaffected unless ack is asserted.
- stop, any state: state=IDLE, cnt=0, out=0 on the next edge.
  - start&&stop in the same cycle: stop wins.
  - stop does not set done.
- DELAY, count=1:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: state=PULSE, cnt=width, out rises.
- PULSE, count=1:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0 with periodic=1: state=DELAY, cnt=delay, out falls.
  - cnt==0 with periodic=0: state=IDLE, out falls, done<=1.
- count=0: cnt and state hold. start, stop, ack and reset still act.
- Timing with count tied high and start sampled at edge E:
  - out rises at edge E+delay+1.
  - out is high for exactly width+1 cycles.
  - Periodic period is delay+width+2 cycles.
  - delay=0 and width=0 are legal: 1-cycle wait, 1-cycle pulse.
- Values are unsigned. cnt never wraps: decrement only when cnt!=0.
- Changes to delay/width while running take effect only at the next sample point.
- done/ack: ack clears done. Simultaneous set and ack: set wins, done=1.
- IDLE with no start: everything holds and out stays 0.

Optional Feature:
- Macro PULSE_GEN_BURST_EN.
- When defined, adds:
  - input burst[7:0], sampled on start;
  - output pulses_left[7:0].
- In periodic mode, the block emits exactly burst+1 pulses.
  - pulses_left is loaded with burst on start and decremented at each pulse end.
  - At the end of the last pulse: state=IDLE, done<=1.
  - Reset and stop clear pulses_left to 0.
- When not defined: no extra ports, and periodic mode runs until stop or reset.

Test Plan:
- Reset then idle: sysrst pulsed mid-cycle (async), no start -> out=0, busy=0, done=0, remaining=0 immediately and held for 50 cycles.
- One-shot, count=1, delay=3, width=2, periodic=0, start at edge E -> out high on edges E+4..E+6 (3 cycles), done=1 from E+7, busy=0; ack -> done=0.
- Periodic, delay=0, width=0, periodic=1 -> out toggles 0/1 with period 2 and 1-cycle pulses; stop -> out=0, busy=0 on next edge, done stays 0.
- Gated count: delay=1, width=1, count=1 only every 4th cycle -> out rises after the 2nd tick and falls after 2 more ticks; remaining holds between ticks.
- Restart and conflicts: restart via start during PULSE -> out falls next edge, cnt=delay. start&&stop together -> IDLE. ack concurrent with done set -> done=1.
- PULSE_GEN_BURST_EN: burst=2, delay=1, width=0, periodic=1 -> exactly 3 pulses, then IDLE with done=1 and pulses_left=0. Without the macro, the same stimulus yields continuous pulses.
